// File: rtl/spi_reg_bank.sv
// Command decoder and register bank behind spi_slave: one command byte opens a
// read or write burst with address auto-increment, and the next tx byte is supplied back.
module spi_reg_bank #(
    parameter logic [7:0] FPGA_VERSION  = 8'hC2,
    parameter logic [7:0] UART_INV_RST  = 8'h00,
    parameter logic [7:0] TELEM_SEL_RST = 8'h00
) (
    input  logic       clk_core,
    input  logic       reset,
    input  logic       transaction_begin,
    input  logic       rx_byte_available,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic       bootloader_force,
    output logic [7:0] uart_inverted,
    output logic [7:0] telemetry_con_sel
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0] sh_q, sh_d;
    logic [1:0] state_q, state_d;
    logic       dir_q, dir_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] tx_q, tx_d;
    logic       force_q, force_d;
    logic [7:0] uart_q, uart_d;
    logic [7:0] telem_q, telem_d;
    logic [7:0] scratch_q, scratch_d;
    logic [7:0] err_q, err_d;

    logic       byte_stb;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] err_inc;

    assign byte_stb = (sh_q == 2'b01);
    assign err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

    // The command byte addresses its own read; inside a read burst we prefetch addr+1.
    assign rd_addr = (state_q == ST_CMD) ? rx_byte[6:0] : addr_q + 7'd1;

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            7'h00:   rd_data = FPGA_VERSION;
            7'h01:   rd_data = {7'b0, force_q};
            7'h02:   rd_data = uart_q;
            7'h03:   rd_data = telem_q;
            7'h04:   rd_data = scratch_q;
            7'h05:   rd_data = err_q;
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        sh_d      = {sh_q[0], rx_byte_available};
        state_d   = state_q;
        dir_d     = dir_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        force_d   = force_q;
        uart_d    = uart_q;
        telem_d   = telem_q;
        scratch_d = scratch_q;
        err_d     = err_q;

        // A new SS framing always wins; a coincident byte strobe is dropped.
        if (transaction_begin) begin
            state_d = ST_CMD;
            tx_d    = 8'h00;
        end else if (byte_stb) begin
            case (state_q)
                ST_CMD: begin
                    dir_d   = rx_byte[7];
                    addr_d  = rx_byte[6:0];
                    state_d = ST_DATA;
                    tx_d    = rx_byte[7] ? 8'h00 : rd_data;
                end
                ST_DATA: begin
                    addr_d = addr_q + 7'd1;
                    if (dir_q) begin
                        tx_d = 8'h00;
                        case (addr_q)
                            7'h01:   force_d   = rx_byte[0];
                            7'h02:   uart_d    = rx_byte;
                            7'h03:   telem_d   = rx_byte;
                            7'h04:   scratch_d = rx_byte;
                            7'h05:   err_d     = 8'h00;
                            default: err_d     = err_inc;
                        endcase
                    end else begin
                        tx_d = rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            sh_q      <= 2'b00;
            state_q   <= ST_IDLE;
            dir_q     <= 1'b0;
            addr_q    <= 7'h00;
            tx_q      <= 8'h00;
            force_q   <= 1'b0;
            uart_q    <= UART_INV_RST;
            telem_q   <= TELEM_SEL_RST;
            scratch_q <= 8'h00;
            err_q     <= 8'h00;
        end else begin
            sh_q      <= sh_d;
            state_q   <= state_d;
            dir_q     <= dir_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            force_q   <= force_d;
            uart_q    <= uart_d;
            telem_q   <= telem_d;
            scratch_q <= scratch_d;
            err_q     <= err_d;
        end
    end

    assign tx_byte           = tx_q;
    assign bootloader_force  = force_q;
    assign uart_inverted     = uart_q;
    assign telemetry_con_sel = telem_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed scenarios followed by random bursts, all checked
// against a transaction-level model of the register map.
module tb_spi_reg_bank;

    localparam logic [7:0] VER = 8'hC2;

    logic       clk_core = 1'b0;
    logic       reset = 1'b1;
    logic       transaction_begin = 1'b0;
    logic       rx_byte_available = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic       bootloader_force;
    logic [7:0] uart_inverted;
    logic [7:0] telemetry_con_sel;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a burst is "framed" after SS; byte count since SS selects command vs data.
    bit         m_framed;
    int         m_count;
    bit         m_write;
    int         m_addr;
    bit         m_force;
    logic [7:0] m_uart, m_telem, m_scratch, m_tx;
    int         m_err;

    spi_reg_bank dut (
        .clk_core          (clk_core),
        .reset             (reset),
        .transaction_begin (transaction_begin),
        .rx_byte_available (rx_byte_available),
        .rx_byte           (rx_byte),
        .tx_byte           (tx_byte),
        .bootloader_force  (bootloader_force),
        .uart_inverted     (uart_inverted),
        .telemetry_con_sel (telemetry_con_sel)
    );

    always #5 clk_core = ~clk_core;

    function automatic logic [7:0] m_read(input int a);
        case (a)
            0:       return VER;
            1:       return {7'b0, m_force};
            2:       return m_uart;
            3:       return m_telem;
            4:       return m_scratch;
            5:       return m_err[7:0];
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_reset();
        m_framed = 0; m_count = 0; m_write = 0; m_addr = 0;
        m_force = 0; m_uart = 8'h00; m_telem = 8'h00; m_scratch = 8'h00;
        m_err = 0; m_tx = 8'h00;
    endtask

    task automatic m_byte(input logic [7:0] b);
        if (!m_framed) return;
        if (m_count == 0) begin
            m_write = b[7];
            m_addr  = int'(b[6:0]);
            m_tx    = m_write ? 8'h00 : m_read(m_addr);
        end else if (m_write) begin
            case (m_addr)
                1:       m_force   = b[0];
                2:       m_uart    = b;
                3:       m_telem   = b;
                4:       m_scratch = b;
                5:       m_err     = 0;
                default: m_err     = (m_err >= 255) ? 255 : m_err + 1;
            endcase
            m_addr = (m_addr + 1) % 128;
            m_tx   = 8'h00;
        end else begin
            m_addr = (m_addr + 1) % 128;
            m_tx   = m_read(m_addr);
        end
        m_count++;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check8({tag, ".tx"}, tx_byte, m_tx);
        check8({tag, ".force"}, {7'b0, bootloader_force}, {7'b0, m_force});
        check8({tag, ".uart"}, uart_inverted, m_uart);
        check8({tag, ".telem"}, telemetry_con_sel, m_telem);
    endtask

    task automatic ss();
        @(negedge clk_core);
        transaction_begin = 1'b1;
        @(negedge clk_core);
        transaction_begin = 1'b0;
        m_framed = 1; m_count = 0; m_tx = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_core);
        rx_byte = b;
        rx_byte_available = 1'b1;
        repeat (4) @(negedge clk_core);
        rx_byte_available = 1'b0;
        repeat (2) @(negedge clk_core);
        m_byte(b);
    endtask

    task automatic pulse_reset();
        @(negedge clk_core);
        reset = 1'b1;
        @(negedge clk_core);
        reset = 1'b0;
        m_reset();
    endtask

    // Byte strobe lands in the same cycle as transaction_begin.
    task automatic collide(input logic [7:0] b);
        @(negedge clk_core);
        rx_byte = b;
        rx_byte_available = 1'b1;
        @(negedge clk_core);
        transaction_begin = 1'b1;
        @(negedge clk_core);
        transaction_begin = 1'b0;
        repeat (2) @(negedge clk_core);
        rx_byte_available = 1'b0;
        repeat (2) @(negedge clk_core);
        m_framed = 1; m_count = 0; m_tx = 8'h00;
    endtask

    initial begin
        m_reset();
        repeat (3) @(negedge clk_core);
        reset = 1'b0;
        @(negedge clk_core);
        check_all("reset");

        ss(); send_byte(8'h00);
        check8("ver_read", tx_byte, 8'hC2); check_all("ver");
        send_byte(8'h5E);
        check8("ver_next", tx_byte, 8'h00); check_all("ver_next");

        ss(); send_byte(8'h81); send_byte(8'h01);
        check8("force_set", {7'b0, bootloader_force}, 8'h01); check_all("force_wr");
        ss(); send_byte(8'h01);
        check8("force_read", tx_byte, 8'h01); check_all("force_rd");

        ss(); send_byte(8'h82); send_byte(8'hA5); send_byte(8'h03); send_byte(8'h5A);
        check8("uart_wr", uart_inverted, 8'hA5);
        check8("telem_wr", telemetry_con_sel, 8'h03);
        check_all("burst_wr");
        ss(); send_byte(8'h02); check8("rd_uart", tx_byte, 8'hA5);
        send_byte(8'h00); check8("rd_telem", tx_byte, 8'h03);
        send_byte(8'h00); check8("rd_scratch", tx_byte, 8'h5A);
        send_byte(8'h00); check8("rd_err0", tx_byte, 8'h00); check_all("burst_rd");

        ss(); send_byte(8'hFF); send_byte(8'h11); send_byte(8'h22); check_all("wrap_wr");
        ss(); send_byte(8'h05); check8("err_2", tx_byte, 8'h02); check_all("err_2");
        ss(); send_byte(8'h01); check8("force_kept", tx_byte, 8'h01);

        for (int k = 0; k < 3; k++) begin
            ss(); send_byte(8'h86);
            for (int j = 0; j < 100; j++) send_byte(8'($urandom));
        end
        ss(); send_byte(8'h05); check8("err_sat", tx_byte, 8'hFF); check_all("err_sat");
        ss(); send_byte(8'h85); send_byte(8'h00);
        ss(); send_byte(8'h05); check8("err_clr", tx_byte, 8'h00); check_all("err_clr");

        ss(); send_byte(8'h83);
        collide(8'h77);
        check8("collide_tx", tx_byte, 8'h00);
        check8("collide_telem", telemetry_con_sel, 8'h03); check_all("collide");
        send_byte(8'h04); check8("collide_cmd", tx_byte, 8'h5A); check_all("collide_cmd");

        ss(); send_byte(8'h82);
        pulse_reset();
        check8("rst_uart", uart_inverted, 8'h00); check_all("rst_mid");
        send_byte(8'h99);
        check8("idle_uart", uart_inverted, 8'h00); check_all("idle_byte");

        for (int t = 0; t < 60; t++) begin
            int n;
            logic [6:0] a;
            logic       w;
            if ($urandom_range(0, 14) == 0) pulse_reset();
            if ($urandom_range(0, 9) == 0) begin
                send_byte(8'($urandom)); check_all("rnd_stray");
            end
            ss();
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            send_byte({w, a}); check_all("rnd_cmd");
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) begin
                send_byte(8'($urandom)); check_all("rnd_data");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
